// File: rtl/frame_sequencer_pkg.sv
// Shared definitions for the frame sequencer: framebuffer geometry and
// the sequencer state encoding.
package frame_sequencer_pkg;

    localparam int unsigned FB_ADDR_W   = 19;
    localparam int unsigned FB_WIDTH    = 640;
    localparam int unsigned FB_HEIGHT   = 480;
    localparam int unsigned FRAMES_W    = 8;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FILL_START = 3'd1,
        FILL_ACK   = 3'd2,
        FILL_WAIT  = 3'd3,
        PLOT_START = 3'd4,
        PLOT_ACK   = 3'd5,
        PLOT_WAIT  = 3'd6,
        SWAP_WAIT  = 3'd7
    } seq_state_t;

endpackage

// File: rtl/frame_sequencer_handshake.sv
// Start pulse, acknowledge timeout and completion detection for one drawer.
// The sequencer owns the phase; this block owns the pulse and the counter.
module drawer_handshake #(
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic start_next,
    input  logic start_phase,
    input  logic ack_phase,
    input  logic wait_phase,
    input  logic ready,
    output logic start,
    output logic ack_c,
    output logic timeout_c,
    output logic done_c
);

    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

    logic [CNT_W-1:0] ack_cnt;

    // Counts cycles spent waiting for the drawer to drop ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            start   <= 1'b0;
            ack_cnt <= '0;
        end else begin
            start <= start_next;
            if (start_phase) begin
                ack_cnt <= '0;
            end else if (ack_phase && (ack_cnt != CNT_W'(ACK_TIMEOUT - 1))) begin
                ack_cnt <= ack_cnt + CNT_W'(1);
            end
        end
    end

    assign ack_c     = ack_phase && !ready;
    assign timeout_c = ack_phase && ready && (ack_cnt == CNT_W'(ACK_TIMEOUT - 1));
    assign done_c    = wait_phase && ready;

endmodule

// File: rtl/frame_sequencer.sv
// Sequences one plot frame: clear back buffer, plot, swap on the next
// frame boundary, and arbitrates the framebuffer write port.
module frame_sequencer
    import frame_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W      = FB_ADDR_W,
    parameter int unsigned PIXEL_W     = 1,
    parameter int unsigned ACK_TIMEOUT = 64,
    parameter bit          CONTINUOUS  = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redraw_req,
    input  logic               frame_start,
    output logic               fill_start,
    input  logic               fill_ready,
    input  logic               fill_wr_en,
    input  logic [ADDR_W-1:0]  fill_wr_addr,
    input  logic [PIXEL_W-1:0] fill_wr_data,
    output logic               plot_start,
    input  logic               plot_ready,
    input  logic               plot_wr_en,
    input  logic [ADDR_W-1:0]  plot_wr_addr,
    input  logic [PIXEL_W-1:0] plot_wr_data,
    output logic               fb_wr_en,
    output logic [ADDR_W-1:0]  fb_wr_addr,
    output logic [PIXEL_W-1:0] fb_wr_data,
    output logic               back_buffer,
    output logic               busy,
    output logic               error,
    output logic [7:0]         frames_drawn
);

    seq_state_t state, state_next;
    logic       pending, pending_next;
    logic       swap_c, err_set_c;
    logic       fill_ack_c, fill_timeout_c, fill_done_c;
    logic       plot_ack_c, plot_timeout_c, plot_done_c;

    drawer_handshake #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_fill_hs (
        .clk         (clk),
        .rst         (rst),
        .start_next  (state_next == FILL_START),
        .start_phase (state == FILL_START),
        .ack_phase   (state == FILL_ACK),
        .wait_phase  (state == FILL_WAIT),
        .ready       (fill_ready),
        .start       (fill_start),
        .ack_c       (fill_ack_c),
        .timeout_c   (fill_timeout_c),
        .done_c      (fill_done_c)
    );

    drawer_handshake #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_plot_hs (
        .clk         (clk),
        .rst         (rst),
        .start_next  (state_next == PLOT_START),
        .start_phase (state == PLOT_START),
        .ack_phase   (state == PLOT_ACK),
        .wait_phase  (state == PLOT_WAIT),
        .ready       (plot_ready),
        .start       (plot_start),
        .ack_c       (plot_ack_c),
        .timeout_c   (plot_timeout_c),
        .done_c      (plot_done_c)
    );

    // State and bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pending      <= 1'b1;
            busy         <= 1'b0;
            back_buffer  <= 1'b0;
            error        <= 1'b0;
            frames_drawn <= '0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            busy    <= (state_next != IDLE);
            if (err_set_c) begin
                error <= 1'b1;
            end
            if (swap_c) begin
                back_buffer  <= ~back_buffer;
                frames_drawn <= frames_drawn + 8'd1;
            end
        end
    end

    // Next-state logic; a same-cycle redraw in SWAP_WAIT counts as pending.
    always_comb begin
        state_next = state;
        swap_c     = 1'b0;
        err_set_c  = 1'b0;
        unique case (state)
            IDLE: begin
                if (pending) state_next = FILL_START;
            end
            FILL_START: state_next = FILL_ACK;
            FILL_ACK: begin
                if (fill_ack_c) begin
                    state_next = FILL_WAIT;
                end else if (fill_timeout_c) begin
                    state_next = IDLE;
                    err_set_c  = 1'b1;
                end
            end
            FILL_WAIT: begin
                if (fill_done_c) state_next = PLOT_START;
            end
            PLOT_START: state_next = PLOT_ACK;
            PLOT_ACK: begin
                if (plot_ack_c) begin
                    state_next = PLOT_WAIT;
                end else if (plot_timeout_c) begin
                    state_next = IDLE;
                    err_set_c  = 1'b1;
                end
            end
            PLOT_WAIT: begin
                if (plot_done_c) state_next = SWAP_WAIT;
            end
            SWAP_WAIT: begin
                if (frame_start) begin
                    swap_c     = 1'b1;
                    state_next = (pending || redraw_req) ? FILL_START : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (CONTINUOUS) begin
            pending_next = 1'b1;
        end else if (state_next == FILL_START) begin
            pending_next = 1'b0;
        end else begin
            pending_next = pending || redraw_req;
        end
    end

    // Write port goes to whichever drawer owns the current phase.
    always_comb begin
        fb_wr_en   = 1'b0;
        fb_wr_addr = fill_wr_addr;
        fb_wr_data = fill_wr_data;
        case (state)
            FILL_ACK, FILL_WAIT: begin
                fb_wr_en = fill_wr_en;
            end
            PLOT_ACK, PLOT_WAIT: begin
                fb_wr_en   = plot_wr_en;
                fb_wr_addr = plot_wr_addr;
                fb_wr_data = plot_wr_data;
            end
            default: fb_wr_en = 1'b0;
        endcase
    end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
Sequences rendering of one plot frame into the double-buffered framebuffer.
- Pulses fill_drawer (clear the back buffer), then the plotter logic, then swaps buffers on the next frame boundary.
- Arbitrates the single framebuffer write port between the two drawers.
- Sits in the clk_25M175 domain between the expression front-end (PS/2 / UART), the drawers and the VGA scanout.

Parameters:
ADDR_W, 19, framebuffer word address width (640x480 = 307200 < 2^19)
PIXEL_W, 1, framebuffer pixel data width
ACK_TIMEOUT, 64, cycles allowed for a drawer to drop ready after its start pulse
CONTINUOUS, 0, 1 = redraw every frame regardless of redraw_req

Ports:
clk  in  1  pixel clock (25.175 MHz)
rst  in  1  synchronous active-high reset
redraw_req  in  1  one-cycle pulse: expression changed, redraw needed
frame_start  in  1  one-cycle pulse at start of vertical blank
fill_start  out  1  one-cycle start pulse to fill drawer
fill_ready  in  1  fill drawer idle/done level
fill_wr_en / fill_wr_addr / fill_wr_data  in  1 / ADDR_W / PIXEL_W  fill drawer write request
plot_start  out  1  one-cycle start pulse to plotter
plot_ready  in  1  plotter idle/done level
plot_wr_en / plot_wr_addr / plot_wr_data  in  1 / ADDR_W / PIXEL_W  plotter write request
fb_wr_en / fb_wr_addr / fb_wr_data  out  1 / ADDR_W / PIXEL_W  granted write to back buffer
back_buffer  out  1  index of buffer being drawn; scanout reads ~back_buffer
busy  out  1  high in any state except IDLE
error  out  1  sticky: a drawer failed to acknowledge start
frames_drawn  out  8  count of completed swaps, wraps 255->0

Behaviour:
- Reset (synchronous, every cycle rst=1): state=IDLE, fill_start=plot_start=0, back_buffer=0, error=0, frames_drawn=0, pending=1 so one frame is drawn after reset. Reset mid-operation abandons the frame with no swap; drawers are not otherwise signalled.
- pending register: set by redraw_req in any state; cleared on entry to FILL_START. Held at 1 when CONTINUOUS=1.
- States:
  - IDLE: pending=1 -> FILL_START.
  - FILL_START: fill_start=1 for exactly this cycle; clear timeout counter -> FILL_ACK.
  - FILL_ACK: fill_ready=0 -> FILL_WAIT. Counter reaches ACK_TIMEOUT -> set error, go IDLE (pending unchanged).
  - FILL_WAIT: fill_ready=1 -> PLOT_START.
  - PLOT_START / PLOT_ACK / PLOT_WAIT: same as the three fill states, using plot_*. Completion -> SWAP_WAIT.
  - SWAP_WAIT: on frame_start, toggle back_buffer, increment frames_drawn, go FILL_START if pending (including a redraw_req in the same cycle), else IDLE.
- Latency: fill_start is asserted 2 cycles after redraw_req from IDLE (1 cycle to set pending, 1 in IDLE). The swap lands on the first frame_start seen while in SWAP_WAIT; a frame_start in any other state is ignored.
- Write arbitration (combinational, registered outputs not required):
  - FILL_ACK / FILL_WAIT: fb_wr_* = fill_wr_*.
  - PLOT_ACK / PLOT_WAIT: fb_wr_* = plot_wr_*.
  - All other states: fb_wr_en=0.
  - Writes from the non-granted drawer are dropped silently.
- redraw_req during drawing does not restart the frame; it sets pending, giving exactly one extra frame after the swap. Multiple requests coalesce into that one frame.
- error is cleared only by rst.

Decomposition:
- Shared package: state encoding enum/localparams (IDLE, FILL_START, FILL_ACK, FILL_WAIT, PLOT_START, PLOT_ACK, PLOT_WAIT, SWAP_WAIT), FB_ADDR_W=19, FB_WIDTH=640, FB_HEIGHT=480.
- One sub-module is natural: drawer_handshake, the start pulse / ack-timeout / done detection for one drawer, instantiated twice. The write mux stays inline.

Test Plan:
- Release rst, drawer models drop ready 3 cycles after start and raise it 100 cycles later -> fill_start pulse, then plot_start after fill_ready rises. At the next frame_start: back_buffer=1, frames_drawn=1, state IDLE, busy=0.
- redraw_req pulsed twice during PLOT_WAIT -> exactly one further frame after the swap, frames_drawn=2, back_buffer=0, then IDLE.
- Fill model never drops ready -> error=1 after ACK_TIMEOUT=64 cycles, no plot_start, back_buffer unchanged.
- fill_wr_en and plot_wr_en both held 1 with addresses 5 and 9 -> fb_wr_addr=5 during the fill phase, 9 during the plot phase, fb_wr_en=0 in IDLE and SWAP_WAIT.
- frame_start pulses while in PLOT_WAIT -> no swap. redraw_req and frame_start in the same cycle in SWAP_WAIT -> swap, then fill_start on the next cycle.
- rst asserted during FILL_WAIT -> next cycle all outputs at reset values, then a fresh frame begins (pending=1).
